// File: rtl/const_mult_1byroot2_pipe.sv
// Three-stage shift-add multiplier by K = 181/256 (close to 1/sqrt(2)).
// A valid tag rides alongside the data; the clock enable stalls every stage together.
module const_mult_1byroot2_pipe #(
  parameter int unsigned W      = 16,
  parameter int unsigned G      = 8,
  parameter bit          SIGNED = 1'b0,
  parameter bit          ROUND  = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in,
  output logic         o_out_valid,
  output logic [W-1:0] o_out
);

  localparam int unsigned IW = W + G + 1;
  // Half an output LSB; only added when rounding is enabled. Rounding needs G >= 1.
  localparam logic [IW-1:0] RND = ROUND ? (IW'(1) << (G - 1)) : '0;

  function automatic logic [IW-1:0] shr(input logic [IW-1:0] v, input int unsigned k);
    if (SIGNED) return IW'($signed(v) >>> k);
    else        return v >> k;
  endfunction

  logic          w_ext;
  logic [IW-1:0] w_xe;
  logic [IW-1:0] r_a, r_b, r_d1, r_s, r_d2;
  logic          r_v1, r_v2, r_v3;
  logic [W-1:0]  r_out;

  assign w_ext = SIGNED ? i_in[W-1] : 1'b0;
  assign w_xe  = {w_ext, i_in, {G{1'b0}}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_d1  <= '0;
      r_v1  <= 1'b0;
      r_s   <= '0;
      r_d2  <= '0;
      r_v2  <= 1'b0;
      r_out <= '0;
      r_v3  <= 1'b0;
    end else if (i_en) begin
      r_a   <= shr(w_xe, 1) + shr(w_xe, 3);
      r_b   <= shr(w_xe, 4) + shr(w_xe, 6);
      r_d1  <= shr(w_xe, 8);
      r_v1  <= i_in_valid;
      r_s   <= r_a + r_b;
      r_d2  <= r_d1;
      r_v2  <= r_v1;
      // The shift discards the guard bits, which floors in both signednesses.
      r_out <= W'((r_s + r_d2 + RND) >> G);
      r_v3  <= r_v2;
    end
  end

  assign o_out       = r_out;
  assign o_out_valid = r_v3;

endmodule
